// File: rtl/college_grade_bank.sv
// Phased grade bank: teacher entry (OPEN) -> principal review (REVIEW) -> student reads (PUBLISHED).
// Latency: writes land at the sampling edge; student read data/valid appear one cycle after s_req.
// Backpressure: none; illegal or out-of-phase requests are dropped and counted in a saturating rej_cnt.
module college_grade_bank #(
  parameter int N_SUBJ    = 3,
  parameter int DATA_W    = 8,
  parameter int MAX_GRADE = 100,
  localparam int IDX_W    = $clog2(N_SUBJ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              t_wr_en,
  input  logic [IDX_W-1:0]  t_wr_idx,
  input  logic [DATA_W-1:0] t_wr_data,
  input  logic              t_done,
  input  logic              p_wr_en,
  input  logic [IDX_W-1:0]  p_wr_idx,
  input  logic [DATA_W-1:0] p_wr_data,
  input  logic              p_publish,
  input  logic              p_reopen,
  input  logic              s_req,
  input  logic [IDX_W-1:0]  s_idx,
  output logic              s_valid,
  output logic [DATA_W-1:0] s_data,
  output logic [1:0]        state,
  output logic [N_SUBJ-1:0] ovr,
  output logic [7:0]        rej_cnt
);

  // Index bound widened by one bit so a non-power-of-two N_SUBJ compares cleanly.
  localparam logic [IDX_W:0]    NSUBJ_V = (IDX_W+1)'(N_SUBJ);
  localparam logic [DATA_W-1:0] MAX_V   = DATA_W'(MAX_GRADE);

  typedef enum logic [1:0] {
    PH_OPEN   = 2'd0,
    PH_REVIEW = 2'd1,
    PH_PUB    = 2'd2
  } phase_t;

  phase_t            phase;
  logic [DATA_W-1:0] grade [N_SUBJ];

  logic       t_legal;
  logic       p_legal;
  logic       s_idx_ok;
  logic       t_acc;
  logic       p_acc;
  logic       s_acc;
  logic       t_rej;
  logic       p_rej;
  logic       s_rej;
  logic [1:0] rej_inc;
  logic [8:0] rej_sum;
  logic       ovr_clr;

  assign state = phase;

  // Request legality and phase gating; each requester contributes at most one rejection per cycle.
  always_comb begin
    t_legal  = ({1'b0, t_wr_idx} < NSUBJ_V) && (t_wr_data <= MAX_V);
    p_legal  = ({1'b0, p_wr_idx} < NSUBJ_V) && (p_wr_data <= MAX_V);
    s_idx_ok = ({1'b0, s_idx} < NSUBJ_V);

    t_acc = t_wr_en && (phase == PH_OPEN)   && t_legal;
    p_acc = p_wr_en && (phase == PH_REVIEW) && p_legal;
    s_acc = s_req   && (phase == PH_PUB)    && s_idx_ok;

    t_rej = t_wr_en && !t_acc;
    p_rej = p_wr_en && !p_acc;
    s_rej = s_req   && !s_acc;

    rej_inc = 2'(t_rej) + 2'(p_rej) + 2'(s_rej);
    rej_sum = {1'b0, rej_cnt} + 9'(rej_inc);

    // Reopen abandons the review round, so its override flags go away even if
    // a principal write lands in the same cycle. Publish beats reopen in REVIEW.
    ovr_clr = p_reopen &&
              (((phase == PH_REVIEW) && !p_publish) || (phase == PH_PUB));
  end

  // Grade storage: only one writer can be accepted per cycle because the phases are exclusive.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_SUBJ; i++) begin
        grade[i] <= '0;
      end
    end else if (t_acc) begin
      grade[t_wr_idx] <= t_wr_data;
    end else if (p_acc) begin
      grade[p_wr_idx] <= p_wr_data;
    end
  end

  // Phase FSM with override flags; irrelevant transition inputs are silently ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= PH_OPEN;
      ovr   <= '0;
    end else begin
      if (ovr_clr) begin
        ovr <= '0;
      end else if (p_acc) begin
        ovr[p_wr_idx] <= 1'b1;
      end

      case (phase)
        PH_OPEN: begin
          if (t_done) begin
            phase <= PH_REVIEW;
          end
        end
        PH_REVIEW: begin
          if (p_publish) begin
            phase <= PH_PUB;
          end else if (p_reopen) begin
            phase <= PH_OPEN;
          end
        end
        PH_PUB: begin
          if (p_reopen) begin
            phase <= PH_OPEN;
          end
        end
        default: begin
          phase <= PH_OPEN;
        end
      endcase
    end
  end

  // Student read port: one read per cycle, data holds when nothing is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_valid <= 1'b0;
      s_data  <= '0;
    end else begin
      s_valid <= s_acc;
      if (s_acc) begin
        s_data <= grade[s_idx];
      end
    end
  end

  // Rejection counter, saturating at 255.
  always_ff @(posedge clk) begin
    if (rst) begin
      rej_cnt <= '0;
    end else if (rej_sum[8]) begin
      rej_cnt <= 8'hFF;
    end else begin
      rej_cnt <= rej_sum[7:0];
    end
  end

endmodule
